// File: rtl/noc_packet_arbiter_if.sv
// Flit handshake bundle for noc_packet_arbiter.
//   din_msg  : NUM_IN flits concatenated, channel i at [64*i+63:64*i]
//   din_val  : per-channel valid
//   din_rdy  : per-channel ready
//   dout_msg : merged flit
//   dout_val : merged valid
//   dout_rdy : downstream ready
// Modport master is the environment (sources and sink); slave is the arbiter.
interface noc_packet_arbiter_if #(
  parameter int unsigned NUM_IN = 4
);
  logic [64*NUM_IN-1:0] din_msg;
  logic [NUM_IN-1:0]    din_val;
  logic [NUM_IN-1:0]    din_rdy;
  logic [63:0]          dout_msg;
  logic                 dout_val;
  logic                 dout_rdy;

  modport master (
    output din_msg, din_val, dout_rdy,
    input  din_rdy, dout_msg, dout_val
  );

  modport slave (
    input  din_msg, din_val, dout_rdy,
    output din_rdy, dout_msg, dout_val
  );
endinterface

// File: rtl/noc_packet_arbiter.sv
// Packet-level round-robin arbiter merging four 64-bit val/rdy flit channels.
// A winner stays locked from its header through its last payload flit, so
// packets never interleave. The datapath is a combinational mux; only the
// arbitration state (FSM, rr_ptr, owner, cnt) is registered.
// Ports:
//   clk       : clock, rising edge
//   rst       : asynchronous active-high reset
//   bus       : flit handshake bundle (slave side)
//   busy      : high while locked mid-packet
//   cur_owner : selected channel (combinational pick when idle, owner when locked)
module noc_packet_arbiter #(
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned PLEN_LSB = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  noc_packet_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [1:0]           cur_owner
);

  typedef enum logic {StIdle, StFwd} state_e;

  state_e     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;

  logic [1:0]  sel;
  logic [63:0] dout_msg;
  logic        dout_val;
  logic        fire;
  logic [7:0]  plen;

  // Selection never looks at dout_rdy, which keeps the handshake loop-free.
  // Scanning from the far end down lets the candidate nearest rr_ptr win.
  // Reset forces channel 0 so outputs are defined while rst is held.
  always_comb begin
    sel = rr_ptr_q;
    if (rst) begin
      sel = 2'd0;
    end else if (state_q == StFwd) begin
      sel = owner_q;
    end else begin
      for (int k = int'(NUM_IN) - 1; k >= 0; k--) begin
        if (bus.din_val[2'(rr_ptr_q + 2'(k))]) sel = 2'(rr_ptr_q + 2'(k));
      end
    end
  end

  assign dout_msg     = bus.din_msg[{sel, 6'd0} +: 64];
  assign dout_val     = bus.din_val[sel];
  assign bus.dout_msg = dout_msg;
  assign bus.dout_val = dout_val;
  assign fire         = dout_val & bus.dout_rdy;
  assign plen         = dout_msg[PLEN_LSB +: 8];

  always_comb begin
    bus.din_rdy      = '0;
    bus.din_rdy[sel] = bus.dout_rdy;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (fire) begin
          if (plen == 8'd0) begin
            rr_ptr_d = sel + 2'd1;
          end else begin
            state_d = StFwd;
            owner_d = sel;
            cnt_d   = plen;
          end
        end
      end
      StFwd: begin
        if (fire) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) begin
            state_d  = StIdle;
            rr_ptr_d = owner_q + 2'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      rr_ptr_q <= 2'd0;
      owner_q  <= 2'd0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy      = (state_q == StFwd);
  assign cur_owner = sel;

endmodule

// File: tb/tb_noc_packet_arbiter.sv
module tb_noc_packet_arbiter;

  logic       clk;
  logic       rst;
  logic       busy;
  logic [1:0] cur_owner;

  noc_packet_arbiter_if #(.NUM_IN(4)) bus ();

  noc_packet_arbiter #(
    .NUM_IN  (4),
    .PLEN_LSB(22)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .cur_owner(cur_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Per-channel source FIFOs: tail advanced by stimulus, head by the handshake.
  logic [63:0] src_mem [4][64];
  int          src_head [4];
  int          src_tail [4];
  logic [3:0]  hold;
  logic [3:0]  flush;
  logic [3:0]  fired;
  logic [3:0]  src_val;
  logic [255:0] src_msg;

  logic [63:0] exp_q[$];

  always_comb begin
    src_val = '0;
    src_msg = '0;
    for (int i = 0; i < 4; i++) begin
      src_val[i]          = (src_head[i] != src_tail[i]) && !hold[i];
      src_msg[64*i +: 64] = src_mem[i][src_head[i] % 64];
    end
  end

  assign bus.din_val = src_val;
  assign bus.din_msg = src_msg;

  always @(negedge clk) fired <= rst ? 4'b0 : (bus.din_val & bus.din_rdy);

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (flush[i]) src_head[i] <= src_tail[i];
      else if (fired[i]) src_head[i] <= src_head[i] + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Scoreboard monitor: every accepted output flit must be the next expected one.
  always @(negedge clk) begin
    if (!rst && bus.dout_val && bus.dout_rdy) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got %h, expected no transfer at %0t", bus.dout_msg, $time);
      end else begin
        check("sb_flit", bus.dout_msg, exp_q.pop_front());
      end
    end
  end

  function automatic logic [63:0] flit(input int ch, input int id, input int plen);
    logic [7:0]  c8;
    logic [15:0] i16;
    logic [7:0]  p8;
    c8  = 8'(ch);
    i16 = 16'(id);
    p8  = 8'(plen);
    return {8'hA5, c8, i16, 2'b00, p8, 22'h0};
  endfunction

  task automatic push_src(input int ch, input logic [63:0] f);
    src_mem[ch][src_tail[ch] % 64] = f;
    src_tail[ch] = src_tail[ch] + 1;
  endtask

  // Queue header + plen payloads on channel ch; the first nexp flits are expected out.
  task automatic send_pkt(input int ch, input int id, input int plen, input int nexp);
    logic [63:0] f;
    for (int k = 0; k <= plen; k++) begin
      f = (k == 0) ? flit(ch, id, plen) : flit(ch, id + k, 0);
      push_src(ch, f);
      if (k < nexp) exp_q.push_back(f);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string name, input logic b, input logic [1:0] o);
    check({name, "_busy"}, 64'(busy), 64'(b));
    check({name, "_owner"}, 64'(cur_owner), 64'(o));
  endtask

  initial begin
    rst = 1'b1;
    bus.dout_rdy = 1'b1;
    hold = '0;
    flush = '0;
    fired = '0;
    for (int i = 0; i < 4; i++) begin
      src_head[i] = 0;
      src_tail[i] = 0;
    end

    // Reset state, then a single plen=0 header on ch0.
    @(negedge clk);
    chk_state("rst", 1'b0, 2'd0);
    check("rst_rdy", 64'(bus.din_rdy), 64'h1);
    cyc();
    rst = 1'b0;
    send_pkt(0, 'h10, 0, 1);
    @(negedge clk);
    chk_state("t1_hdr", 1'b0, 2'd0);
    check("t1_val", 64'(bus.dout_val), 64'h1);
    cyc();
    @(negedge clk);
    chk_state("t1_after", 1'b0, 2'd1);
    check("t1_drained", 64'(exp_q.size()), 64'h0);

    // ch0 plen=2 and ch1 plen=1, both valid from the first cycle after reset.
    cyc();
    rst = 1'b1;
    send_pkt(0, 'h20, 2, 3);
    send_pkt(1, 'h30, 1, 2);
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk_state("t2_c0", 1'b0, 2'd0);
    check("t2_c0_rdy", 64'(bus.din_rdy), 64'h1);
    cyc(); @(negedge clk);
    chk_state("t2_c1", 1'b1, 2'd0);
    check("t2_c1_rdy", 64'(bus.din_rdy), 64'h1);
    cyc(); @(negedge clk);
    chk_state("t2_c2", 1'b1, 2'd0);
    check("t2_c2_rdy", 64'(bus.din_rdy), 64'h1);
    cyc(); @(negedge clk);
    chk_state("t2_c3", 1'b0, 2'd1);
    check("t2_c3_rdy", 64'(bus.din_rdy), 64'h2);
    cyc(); @(negedge clk);
    chk_state("t2_c4", 1'b1, 2'd1);
    cyc(); @(negedge clk);
    chk_state("t2_c5", 1'b0, 2'd2);
    check("t2_c5_val", 64'(bus.dout_val), 64'h0);
    check("t2_drained", 64'(exp_q.size()), 64'h0);

    // All four channels streaming plen=0 headers: strict rotation, one per cycle.
    cyc();
    rst = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        push_src(c, flit(c, 'h40 + r * 4 + c, 0));
        exp_q.push_back(flit(c, 'h40 + r * 4 + c, 0));
      end
    end
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("t3_val", 64'(bus.dout_val), 64'h1);
      check("t3_owner", 64'(cur_owner), 64'(k % 4));
      cyc();
    end
    @(negedge clk);
    chk_state("t3_end", 1'b0, 2'd0);
    check("t3_drained", 64'(exp_q.size()), 64'h0);

    // ch2 plen=3, downstream stalls five cycles after the first payload.
    cyc();
    send_pkt(2, 'h50, 3, 4);
    @(negedge clk);
    chk_state("t4_hdr", 1'b0, 2'd2);
    check("t4_hdr_rdy", 64'(bus.din_rdy), 64'h4);
    cyc(); @(negedge clk);
    chk_state("t4_p0", 1'b1, 2'd2);
    cyc();
    bus.dout_rdy = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk_state("t4_stall", 1'b1, 2'd2);
      check("t4_stall_rdy", 64'(bus.din_rdy), 64'h0);
      cyc();
    end
    bus.dout_rdy = 1'b1;
    @(negedge clk);
    chk_state("t4_p1", 1'b1, 2'd2);
    cyc(); @(negedge clk);
    chk_state("t4_p2", 1'b1, 2'd2);
    cyc(); @(negedge clk);
    chk_state("t4_end", 1'b0, 2'd3);
    check("t4_drained", 64'(exp_q.size()), 64'h0);

    // ch1 locked with a 3-cycle bubble while ch3 waits; ch3 must not cut in.
    cyc();
    send_pkt(1, 'h60, 3, 4);
    @(negedge clk);
    chk_state("t5_hdr", 1'b0, 2'd1);
    cyc();
    send_pkt(3, 'h70, 0, 1);
    @(negedge clk);
    chk_state("t5_p0", 1'b1, 2'd1);
    cyc();
    hold[1] = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk_state("t5_bubble", 1'b1, 2'd1);
      check("t5_bubble_val", 64'(bus.dout_val), 64'h0);
      check("t5_bubble_rdy", 64'(bus.din_rdy), 64'h2);
      cyc();
    end
    hold[1] = 1'b0;
    @(negedge clk);
    chk_state("t5_p1", 1'b1, 2'd1);
    cyc(); @(negedge clk);
    chk_state("t5_p2", 1'b1, 2'd1);
    cyc(); @(negedge clk);
    chk_state("t5_ch3", 1'b0, 2'd3);
    check("t5_ch3_rdy", 64'(bus.din_rdy), 64'h8);
    cyc(); @(negedge clk);
    chk_state("t5_end", 1'b0, 2'd0);
    check("t5_drained", 64'(exp_q.size()), 64'h0);

    // Reset mid-packet with cnt=5, then a fresh ch0 packet.
    cyc();
    send_pkt(0, 'h80, 8, 4);
    @(negedge clk);
    chk_state("t6_hdr", 1'b0, 2'd0);
    for (int j = 0; j < 3; j++) begin
      cyc(); @(negedge clk);
      chk_state("t6_pay", 1'b1, 2'd0);
    end
    cyc();
    rst = 1'b1;
    #1;
    chk_state("t6_rst", 1'b0, 2'd0);
    check("t6_rst_rdy", 64'(bus.din_rdy), 64'h1);
    check("t6_rst_msg", bus.dout_msg, flit(0, 'h84, 0));
    flush[0] = 1'b1;
    cyc();
    flush[0] = 1'b0;
    rst = 1'b0;
    send_pkt(0, 'h90, 1, 2);
    @(negedge clk);
    chk_state("t6_new_hdr", 1'b0, 2'd0);
    cyc(); @(negedge clk);
    chk_state("t6_new_p0", 1'b1, 2'd0);
    cyc(); @(negedge clk);
    chk_state("t6_end", 1'b0, 2'd1);
    check("t6_drained", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/noc_packet_arbiter.md
# noc_packet_arbiter

Packet-level round-robin arbiter that merges four 64-bit val/rdy NoC flit channels into one output channel. A winning input is locked from its header flit through its last payload flit, so packets are never interleaved. It sits wherever several NoC sources share one link, directly upstream of a link that may carry a tracing tap. The datapath is a zero-latency combinational mux; only the arbitration state is registered.

## Interface
Parameters:
- NUM_IN, 4: number of input channels; fixed at 4 in this revision. The pointer and owner fields are 2 bits.
- PLEN_LSB, 22: LSB of the 8-bit payload-length field in a header flit. The field is din_msg[29:22].

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- din_msg  input  256  four flits concatenated; channel i is bits [64*i+63:64*i].
- din_val  input  4  per-channel valid.
- din_rdy  output  4  per-channel ready.
- dout_msg  output  64  merged flit.
- dout_val  output  1  merged valid.
- dout_rdy  input  1  downstream ready.
- busy  output  1  high while locked mid-packet (state FWD).
- cur_owner  output  2  selected channel index; in IDLE this is the combinational pick, in FWD the locked owner.

## Operation
State: 1-bit FSM {IDLE, FWD}, 2-bit rr_ptr, 2-bit owner, 8-bit cnt.

Selection:
- IDLE: sel = first index i with din_val[i]=1, searching rr_ptr, rr_ptr+1, … modulo 4.
- IDLE with no valid input: sel = rr_ptr.
- FWD: sel = owner.
- sel must never depend on dout_rdy. This avoids a combinational loop.

Datapath:
- dout_msg = din_msg[sel].
- dout_val = din_val[sel].
- din_rdy[i] = dout_rdy & (i == sel). All other din_rdy bits are 0.
- A transfer (fire) occurs when dout_val & dout_rdy.

IDLE (header):
- Re-arbitrates every cycle. Nothing is committed until fire.
- On fire with plen = 0: stay IDLE; rr_ptr <= sel + 1 (mod 4).
- On fire with plen ≠ 0: go to FWD; owner <= sel; cnt <= plen.

FWD (payload):
- Each fire: cnt <= cnt − 1.
- Fire with cnt = 1: go to IDLE; rr_ptr <= owner + 1.
- No fire: hold all state.
- Other inputs' valids are ignored until the packet ends.

Arithmetic and widths:
- cnt is 8-bit unsigned, so a packet is 1–256 flits.
- rr_ptr and owner wrap 3 → 0.

Reset (asynchronous, may occur mid-packet):
- State, rr_ptr, owner and cnt clear to IDLE/0 immediately.
- Outputs on reset: busy=0, cur_owner=0, din_rdy=4'b0001 & {4{dout_rdy}}, dout_val=din_val[0], dout_msg=din_msg[63:0].
- A truncated packet is acceptable; upstream and downstream are reset together.

## Timing
- Zero-cycle flit latency: dout follows din of sel combinationally in the same cycle.
- A packet of plen payload flits needs at least plen+1 cycles.
- A new header can fire in the cycle right after the last payload flit. No dead cycle between packets.
- Simultaneous valids in IDLE: round-robin priority from rr_ptr. The last winner gets lowest priority next time.
- A source that drops din_val before fire loses nothing. Arbitration simply re-evaluates.
- dout_rdy low: no fire, all din_rdy low, state frozen.
- An owner bubble (din_val low in FWD) does not release the lock.
- busy rises the cycle after a header fire with plen≠0. It falls the cycle after the final payload fire.

## Test plan
- Reset, then din_val=0001 with a plen=0 header and dout_rdy=1 → one fire, dout_msg = ch0 flit, busy stays 0, rr_ptr=1.
- Reset, ch0 sends plen=2 and ch1 sends plen=1, both valid from cycle 0 → output order ch0 H, P, P, then ch1 H, P. busy=1 for exactly the two ch0 payload cycles and the one ch1 payload cycle. din_rdy[1]=0 during ch0's packet.
- All four channels continuously sending plen=0 headers → grant order 0,1,2,3,0,1… with exactly one fire per cycle.
- ch2 locked with plen=3; hold dout_rdy=0 for 5 cycles after the first payload → cnt stays 2, cur_owner=2, din_rdy=0000. Packet resumes and completes when dout_rdy returns.
- ch1 locked; its din_val drops for 3 cycles mid-payload while ch3 is valid → no ch3 transfer until ch1's last payload. Then ch3 wins (rr_ptr=2).
- Assert rst for one cycle mid-payload (cnt=5) → busy=0 and cur_owner=0 within the same cycle. The next ch0 header is accepted as a new packet.
